// File: rtl/sys_pll_reset_sequencer.sv
// PLL reset and staged SDRAM/CPU reset sequencer clocked by the free-running board reference.
// Retries PLL lock on timeout and latches a failure after MAX_RETRIES consecutive attempts.
module sys_pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int SEQ_DELAY      = 64,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       ext_reset_req_n,
  output logic       pll_rst,
  output logic       sdram_reset_n,
  output logic       cpu_reset_n,
  output logic       lock_fail,
  output logic [3:0] retry_count
);

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (STABLE_CYCLES > SEQ_DELAY) ? STABLE_CYCLES : SEQ_DELAY;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEQ_LAST    = CNT_W'(SEQ_DELAY - 1);
  localparam logic [4:0]       RETRY_LIM   = (MAX_RETRIES > 15) ? 5'd16 : 5'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             retry_q, retry_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sdram_q, sdram_d;
  logic                   cpu_q, cpu_d;
  logic                   fail_q, fail_d;
  logic                   lock_s, ext_s;
  logic [3:0]             retry_inc;

  assign lock_s    = lock_sync_q[SYNC_STAGES-1];
  assign ext_s     = ext_sync_q[SYNC_STAGES-1];
  assign retry_inc = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;

  always_comb begin
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    ext_sync_d  = {ext_sync_q[SYNC_STAGES-2:0], ext_reset_req_n};
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    retry_d     = retry_q;

    // A button press parks the system in STABLE without touching the PLL.
    if (state_q != S_FAIL && !ext_s) begin
      state_d = S_STABLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (cnt_q == PLL_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            // This sample already counts as the first stable lock cycle.
            state_d = S_STABLE;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == LOCK_LAST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = ({1'b0, retry_inc} == RETRY_LIM) ? S_FAIL : S_PLL_RST;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q >= STABLE_LAST) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
          end
        end
        S_RELEASE: begin
          if (!lock_s) begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
          end else if (cnt_q == SEQ_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        S_RUN: begin
          cnt_d = '0;
          if (!lock_s) state_d = S_PLL_RST;
        end
        S_FAIL: begin
          cnt_d = '0;
          if (!ext_s) begin
            state_d = S_PLL_RST;
            retry_d = '0;
          end
        end
        default: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end

    pll_rst_d = (state_d == S_PLL_RST);
    sdram_d   = (state_d == S_RELEASE) || (state_d == S_RUN);
    cpu_d     = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  // The request chain resets to its idle level so leaving reset is not seen as a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_sync_q <= '0;
      ext_sync_q  <= '1;
      pll_rst_q   <= 1'b1;
      sdram_q     <= 1'b0;
      cpu_q       <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_sync_q <= lock_sync_d;
      ext_sync_q  <= ext_sync_d;
      pll_rst_q   <= pll_rst_d;
      sdram_q     <= sdram_d;
      cpu_q       <= cpu_d;
      fail_q      <= fail_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sdram_reset_n = sdram_q;
  assign cpu_reset_n   = cpu_q;
  assign lock_fail     = fail_q;
  assign retry_count   = retry_q;

endmodule

// File: tb/tb_sys_pll_reset_sequencer.sv
// Directed bench for sys_pll_reset_sequencer with shortened timing parameters.
module tb_sys_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       ext_reset_req_n;
  logic       pll_rst;
  logic       sdram_reset_n;
  logic       cpu_reset_n;
  logic       lock_fail;
  logic [3:0] retry_count;

  int errors = 0;
  int checks = 0;

  sys_pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (8),
    .SEQ_DELAY     (3),
    .MAX_RETRIES   (2),
    .SYNC_STAGES   (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .ext_reset_req_n(ext_reset_req_n),
    .pll_rst        (pll_rst),
    .sdram_reset_n  (sdram_reset_n),
    .cpu_reset_n    (cpu_reset_n),
    .lock_fail      (lock_fail),
    .retry_count    (retry_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      if (cpu_reset_n === 1'b1 && sdram_reset_n !== 1'b1) begin
        errors++; $display("FAIL inv_cpu_implies_sdram: cpu=%b sdram=%b, need sdram=1", cpu_reset_n, sdram_reset_n);
      end
      checks++;
      if (pll_rst === 1'b1 && (sdram_reset_n !== 1'b0 || cpu_reset_n !== 1'b0)) begin
        errors++; $display("FAIL inv_pll_rst_holds_resets: sdram=%b cpu=%b, need 0 0", sdram_reset_n, cpu_reset_n);
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0; pll_locked = 1'b0; ext_reset_req_n = 1'b1;
    tick(3);
    checks++; if (pll_rst !== 1'b1)       begin errors++; $display("FAIL rst_pll_rst: got %b want 1", pll_rst); end
    checks++; if (sdram_reset_n !== 1'b0) begin errors++; $display("FAIL rst_sdram: got %b want 0", sdram_reset_n); end
    checks++; if (cpu_reset_n !== 1'b0)   begin errors++; $display("FAIL rst_cpu: got %b want 0", cpu_reset_n); end
    checks++; if (lock_fail !== 1'b0)     begin errors++; $display("FAIL rst_lock_fail: got %b want 0", lock_fail); end
    checks++; if (retry_count !== 4'd0)   begin errors++; $display("FAIL rst_retry: got %0d want 0", retry_count); end
    reset_n = 1'b1;
  endtask

  task automatic test_boot();
    tick(3);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL boot_pll_rst_cycle4: got %b want 1", pll_rst); end
    tick(1);
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL boot_pll_rst_fall: got %b want 0", pll_rst); end
    tick(10);
    pll_locked = 1'b1;
    tick(9);
    checks++; if (sdram_reset_n !== 1'b0) begin errors++; $display("FAIL boot_sdram_early: got %b want 0", sdram_reset_n); end
    tick(1);
    checks++; if (sdram_reset_n !== 1'b1) begin errors++; $display("FAIL boot_sdram_release: got %b want 1", sdram_reset_n); end
    checks++; if (cpu_reset_n !== 1'b0)   begin errors++; $display("FAIL boot_cpu_held: got %b want 0", cpu_reset_n); end
    tick(2);
    checks++; if (cpu_reset_n !== 1'b0)   begin errors++; $display("FAIL boot_cpu_early: got %b want 0", cpu_reset_n); end
    tick(1);
    checks++; if (cpu_reset_n !== 1'b1)   begin errors++; $display("FAIL boot_cpu_release: got %b want 1", cpu_reset_n); end
    checks++; if (retry_count !== 4'd0)   begin errors++; $display("FAIL boot_retry: got %0d want 0", retry_count); end
    checks++; if (pll_rst !== 1'b0)       begin errors++; $display("FAIL boot_pll_rst_run: got %b want 0", pll_rst); end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    tick(2);
    checks++; if (sdram_reset_n !== 1'b1 || cpu_reset_n !== 1'b1) begin
      errors++; $display("FAIL loss_resets_early: got sdram=%b cpu=%b want 1 1", sdram_reset_n, cpu_reset_n); end
    tick(1);
    checks++; if (sdram_reset_n !== 1'b0 || cpu_reset_n !== 1'b0) begin
      errors++; $display("FAIL loss_resets_assert: got sdram=%b cpu=%b want 0 0", sdram_reset_n, cpu_reset_n); end
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst_rise: got %b want 1", pll_rst); end
    tick(3);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst_hold: got %b want 1", pll_rst); end
    tick(1);
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL loss_pll_rst_fall: got %b want 0", pll_rst); end
  endtask

  task automatic test_glitch();
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(4);
    checks++; if (sdram_reset_n !== 1'b0) begin errors++; $display("FAIL glitch_no_release: got %b want 0", sdram_reset_n); end
    checks++; if (pll_rst !== 1'b0)       begin errors++; $display("FAIL glitch_pll_rst: got %b want 0", pll_rst); end
    tick(5);
    checks++; if (sdram_reset_n !== 1'b0) begin errors++; $display("FAIL glitch_sdram_early: got %b want 0", sdram_reset_n); end
    tick(1);
    checks++; if (sdram_reset_n !== 1'b1) begin errors++; $display("FAIL glitch_sdram_release: got %b want 1", sdram_reset_n); end
    tick(3);
    checks++; if (cpu_reset_n !== 1'b1)   begin errors++; $display("FAIL glitch_cpu_release: got %b want 1", cpu_reset_n); end
  endtask

  task automatic test_button();
    ext_reset_req_n = 1'b0;
    tick(2);
    checks++; if (sdram_reset_n !== 1'b1 || cpu_reset_n !== 1'b1) begin
      errors++; $display("FAIL button_early: got sdram=%b cpu=%b want 1 1", sdram_reset_n, cpu_reset_n); end
    tick(1);
    checks++; if (sdram_reset_n !== 1'b0 || cpu_reset_n !== 1'b0) begin
      errors++; $display("FAIL button_assert: got sdram=%b cpu=%b want 0 0", sdram_reset_n, cpu_reset_n); end
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL button_no_pll_rst: got %b want 0", pll_rst); end
    tick(2);
    ext_reset_req_n = 1'b1;
    tick(9);
    checks++; if (sdram_reset_n !== 1'b0) begin errors++; $display("FAIL button_sdram_early: got %b want 0", sdram_reset_n); end
    checks++; if (pll_rst !== 1'b0)       begin errors++; $display("FAIL button_pll_rst_hold: got %b want 0", pll_rst); end
    tick(1);
    checks++; if (sdram_reset_n !== 1'b1) begin errors++; $display("FAIL button_sdram_release: got %b want 1", sdram_reset_n); end
    checks++; if (cpu_reset_n !== 1'b0)   begin errors++; $display("FAIL button_cpu_held: got %b want 0", cpu_reset_n); end
    tick(2);
    checks++; if (cpu_reset_n !== 1'b0)   begin errors++; $display("FAIL button_cpu_early: got %b want 0", cpu_reset_n); end
    tick(1);
    checks++; if (cpu_reset_n !== 1'b1)   begin errors++; $display("FAIL button_cpu_release: got %b want 1", cpu_reset_n); end
  endtask

  task automatic test_async_reset();
    ext_reset_req_n = 1'b0;
    tick(1);
    ext_reset_req_n = 1'b1;
    tick(10);
    checks++; if (sdram_reset_n !== 1'b1 || cpu_reset_n !== 1'b0) begin
      errors++; $display("FAIL async_in_release: got sdram=%b cpu=%b want 1 0", sdram_reset_n, cpu_reset_n); end
    tick(1);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1)       begin errors++; $display("FAIL async_pll_rst: got %b want 1", pll_rst); end
    checks++; if (sdram_reset_n !== 1'b0) begin errors++; $display("FAIL async_sdram: got %b want 0", sdram_reset_n); end
    checks++; if (cpu_reset_n !== 1'b0)   begin errors++; $display("FAIL async_cpu: got %b want 0", cpu_reset_n); end
    checks++; if (lock_fail !== 1'b0 || retry_count !== 4'd0) begin
      errors++; $display("FAIL async_status: got fail=%b retry=%0d want 0 0", lock_fail, retry_count); end
  endtask

  task automatic test_timeouts();
    pll_locked = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    checks++; if (pll_rst !== 1'b0)     begin errors++; $display("FAIL to_pll_rst_fall: got %b want 0", pll_rst); end
    tick(99);
    checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL to_retry_early: got %0d want 0", retry_count); end
    tick(1);
    checks++; if (retry_count !== 4'd1) begin errors++; $display("FAIL to_retry_1: got %0d want 1", retry_count); end
    checks++; if (pll_rst !== 1'b1 || lock_fail !== 1'b0) begin
      errors++; $display("FAIL to_retry_pll_rst: got pll_rst=%b fail=%b want 1 0", pll_rst, lock_fail); end
    tick(3);
    checks++; if (pll_rst !== 1'b1)     begin errors++; $display("FAIL to_pll_rst_hold: got %b want 1", pll_rst); end
    tick(1);
    checks++; if (pll_rst !== 1'b0)     begin errors++; $display("FAIL to_pll_rst_fall2: got %b want 0", pll_rst); end
    tick(99);
    checks++; if (lock_fail !== 1'b0 || retry_count !== 4'd1) begin
      errors++; $display("FAIL to_fail_early: got fail=%b retry=%0d want 0 1", lock_fail, retry_count); end
    tick(1);
    checks++; if (lock_fail !== 1'b1 || retry_count !== 4'd2) begin
      errors++; $display("FAIL to_fail_enter: got fail=%b retry=%0d want 1 2", lock_fail, retry_count); end
    checks++; if (pll_rst !== 1'b0 || sdram_reset_n !== 1'b0 || cpu_reset_n !== 1'b0) begin
      errors++; $display("FAIL to_fail_outputs: got pll_rst=%b sdram=%b cpu=%b want 0 0 0", pll_rst, sdram_reset_n, cpu_reset_n); end
    tick(20);
    checks++; if (lock_fail !== 1'b1 || pll_rst !== 1'b0) begin
      errors++; $display("FAIL to_fail_sticky: got fail=%b pll_rst=%b want 1 0", lock_fail, pll_rst); end
    ext_reset_req_n = 1'b0;
    tick(1);
    ext_reset_req_n = 1'b1;
    tick(1);
    checks++; if (lock_fail !== 1'b1) begin errors++; $display("FAIL to_exit_early: got %b want 1", lock_fail); end
    tick(1);
    checks++; if (lock_fail !== 1'b0 || pll_rst !== 1'b1 || retry_count !== 4'd0) begin
      errors++; $display("FAIL to_exit: got fail=%b pll_rst=%b retry=%0d want 0 1 0", lock_fail, pll_rst, retry_count); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_lock_loss();
    test_glitch();
    test_button();
    test_async_reset();
    test_timeouts();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
